// File: rtl/vga_frame_capture.sv
// Captures one VGA frame as 1-bit thresholded pixels packed MSB-first into words,
// buffered in a small FIFO toward a valid/ready memory write port. Optional CRC: FRAME_CRC_EN.
module vga_frame_capture #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int PIXEL_BITS    = 12,
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     start_in,
  input  logic                     video_on_in,
  input  logic                     v_sync_in,
  input  logic [PIXEL_BITS-1:0]    pixel_in,
  input  logic                     write_ready_in,
  output logic                     write_valid_out,
  output logic [ADDRESS_WIDTH-1:0] write_address_out,
  output logic [WORD_WIDTH-1:0]    write_data_out,
  output logic                     busy_out,
  output logic                     frame_done_out,
  output logic                     overflow_out,
  output logic                     short_frame_out,
  output logic [15:0]              crc_out
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PCW   = $clog2(TOTAL + 1);
  localparam int BCW   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int PTRW  = $clog2(FIFO_DEPTH);
  localparam logic [PCW-1:0] LAST_PIXEL = PCW'(TOTAL);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DRAIN, DONE} state_t;
  state_t state;

  logic [WORD_WIDTH-1:0]    shift_p0;
  logic [WORD_WIDTH-1:0]    word_p1;
  logic                     vld_p1;
  logic [BCW-1:0]           bit_count;
  logic [PCW-1:0]           pixel_count;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0]    fifo_data    [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_address [FIFO_DEPTH];
  logic [PTRW:0]            wr_ptr;
  logic [PTRW:0]            rd_ptr;
  logic fifo_empty, fifo_full, pop, accept, sample, pixel_bit, last_bit;

  assign pixel_bit  = |pixel_in;
  assign sample     = (state == CAPTURE) && v_sync_in && video_on_in && (pixel_count < LAST_PIXEL);
  assign last_bit   = (bit_count == LAST_BIT);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTRW] != rd_ptr[PTRW]) && (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]);
  assign pop        = !fifo_empty && write_ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept     = vld_p1 && (!fifo_full || pop);

  assign write_valid_out   = !fifo_empty;
  assign write_address_out = fifo_empty ? '0 : fifo_address[rd_ptr[PTRW-1:0]];
  assign write_data_out    = fifo_empty ? '0 : fifo_data[rd_ptr[PTRW-1:0]];

  // Stage p0: shift pixel bits in; p1: completed word waits one edge for the FIFO push
  always_ff @(posedge clock_in) begin
    if (sample) begin
      shift_p0 <= {shift_p0[WORD_WIDTH-2:0], pixel_bit};
      if (last_bit) word_p1 <= {shift_p0[WORD_WIDTH-2:0], pixel_bit};
    end
    if (accept) begin
      fifo_data[wr_ptr[PTRW-1:0]]    <= word_p1;
      fifo_address[wr_ptr[PTRW-1:0]] <= address;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state           <= IDLE;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      overflow_out    <= 1'b0;
      short_frame_out <= 1'b0;
      vld_p1          <= 1'b0;
      bit_count       <= '0;
      pixel_count     <= '0;
      address         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
    end else begin
      vld_p1 <= sample && last_bit;
      if (sample) begin
        bit_count   <= last_bit ? '0 : bit_count + 1'b1;
        pixel_count <= pixel_count + 1'b1;
      end
      // Dropped words still consume an address so later words land in place.
      if (vld_p1) address <= address + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (vld_p1 && !accept) overflow_out <= 1'b1;

      case (state)
        IDLE: begin
          if (start_in) begin
            overflow_out    <= 1'b0;
            short_frame_out <= 1'b0;
            pixel_count     <= '0;
            bit_count       <= '0;
            address         <= '0;
            busy_out        <= 1'b1;
            state           <= ARM;
          end
        end
        ARM:  if (!v_sync_in) state <= SYNC;
        SYNC: if (v_sync_in) state <= CAPTURE;
        CAPTURE: begin
          if (vld_p1 && pixel_count == LAST_PIXEL) begin
            state <= DRAIN;
          end else if (!v_sync_in) begin
            short_frame_out <= 1'b1;
            bit_count       <= '0;
            state           <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !vld_p1) begin
            frame_done_out <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          frame_done_out <= 1'b0;
          busy_out       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_update(input logic [15:0] crc_in,
                                             input logic [WORD_WIDTH-1:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)                  crc <= '0;
    else if (state == IDLE && start_in) crc <= 16'hFFFF;
    else if (vld_p1)                  crc <= crc_update(crc, word_p1);
  end

  assign crc_out = crc;
`else
  assign crc_out = '0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomized frame-capture bench with a queue-based reference model and per-cycle compare.
module tb_vga_frame_capture;
  localparam int W = 64, H = 20, PB = 12, WW = 16, AW = 16, FD = 4;
  localparam int TOTAL = W * H, WORDS = TOTAL / WW;

  logic clk = 0, rst_n = 1, start = 0, video_on = 0, vsync = 1, ready = 1;
  logic [PB-1:0] pixel = '0;
  logic valid, busy, done, ovf, shrt;
  logic [AW-1:0] waddr;
  logic [WW-1:0] wdata;
  logic [15:0] crc;

  always #5 clk = ~clk;

  vga_frame_capture #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(PB), .WORD_WIDTH(WW),
                      .ADDRESS_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start), .video_on_in(video_on),
    .v_sync_in(vsync), .pixel_in(pixel), .write_ready_in(ready),
    .write_valid_out(valid), .write_address_out(waddr), .write_data_out(wdata),
    .busy_out(busy), .frame_done_out(done), .overflow_out(ovf),
    .short_frame_out(shrt), .crc_out(crc));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of thresholded pixels, words are
  // groups of 16 of them, and the FIFO is a bounded queue of {address,data}.
  typedef enum int {P_IDLE, P_ARM, P_SYNC, P_CAP, P_DRAIN, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  int n = 0, m_addr = 0, pre = 0;
  logic [15:0] cur = 0, pend_word = 0;
  bit pend = 0, was_pend = 0, m_ovf = 0, m_short = 0;
  logic [31:0] mq[$];
  logic [15:0] pushed[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; n = 0; cur = 0; pend = 0; pend_word = 0; m_addr = 0;
      m_ovf = 0; m_short = 0; mq.delete(); pushed.delete();
    end else begin
      pre = mq.size();
      if (pre > 0 && ready) mq.delete(0);
      was_pend = pend;
      pend = 0;
      if (was_pend) begin
        pushed.push_back(pend_word);
        if (mq.size() < FD) mq.push_back({m_addr[15:0], pend_word});
        else m_ovf = 1;
        m_addr++;
      end
      case (ph)
        P_IDLE: if (start) begin
          m_ovf = 0; m_short = 0; n = 0; m_addr = 0; pushed.delete(); ph = P_ARM;
        end
        P_ARM:  if (!vsync) ph = P_SYNC;
        P_SYNC: if (vsync) ph = P_CAP;
        P_CAP: begin
          if (was_pend && n == TOTAL) ph = P_DRAIN;
          else if (!vsync) begin m_short = 1; ph = P_DRAIN; end
          else if (video_on && n < TOTAL) begin
            cur = {cur[14:0], pixel != 0};
            n++;
            if (n % WW == 0) begin pend = 1; pend_word = cur; end
          end
        end
        P_DRAIN: if (pre == 0) ph = P_DONE;
        default: ph = P_IDLE;
      endcase
    end
  end

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (pushed[k])
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ pushed[k][b];
        c = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction
`endif

  // Compare process: runs on the falling edge, away from the active edge.
  logic [31:0] log_q[$];
  int done_count = 0;
  bit hold_v = 0;
  logic [15:0] hold_a = 0, hold_d = 0;

  always @(negedge clk) begin
    if (!rst_n) hold_v = 0;
    else if (hold_v && ready) log_q.push_back({hold_a, hold_d});
    else if (hold_v) begin
      check("stall_valid", 32'(valid), 1);
      check("stall_addr", 32'(waddr), 32'(hold_a));
      check("stall_data", 32'(wdata), 32'(hold_d));
    end
    check("valid", 32'(valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("addr", 32'(waddr), 32'(mq[0][31:16]));
      check("data", 32'(wdata), 32'(mq[0][15:0]));
    end
    check("busy", 32'(busy), 32'(ph != P_IDLE));
    check("frame_done", 32'(done), 32'(ph == P_DONE));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("short_frame", 32'(shrt), 32'(m_short));
`ifdef FRAME_CRC_EN
    if (ph == P_DONE) check("crc_done", 32'(crc), 32'(model_crc()));
`else
    check("crc_zero", 32'(crc), 0);
`endif
    if (done) done_count++;
    hold_v = valid; hold_a = waddr; hold_d = wdata;
  end

  int stall_left = 0, rmode = 0, cyc = 0, log_base = 0, done_base = 0;

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (stall_left > 0) begin ready = 0; stall_left--; end
    else case (rmode)
      0: ready = 1;
      1: ready = cyc[0];
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  function automatic logic [PB-1:0] gen(input int kind, input int y, input int x);
    case (kind)
      0: return '0;
      1: return (y == 0 && x < 16) ? 12'hFFF : '0;
      2: return (y == 0 && x == 15) ? 12'hFFF : '0;
      default: return ($urandom_range(0, 2) == 0) ? PB'($urandom) : '0;
    endcase
  endfunction

  function automatic int flen();
    return log_q.size() - log_base;
  endfunction

  function automatic logic [31:0] fl(input int k);
    return log_q[log_base + k];
  endfunction

  task automatic check_reset_outputs();
    check("rst_valid", 32'(valid), 0);
    check("rst_addr", 32'(waddr), 0);
    check("rst_data", 32'(wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(ovf), 0);
    check("rst_short", 32'(shrt), 0);
    check("rst_crc", 32'(crc), 0);
  endtask

  task automatic run_frame(input int kind, input int short_after, input int reset_at,
                           input int stall_at);
    int cnt, budget;
    bit stop;
    log_base = log_q.size();
    done_base = done_count;
    cnt = 0; stop = 0;
    tick(); start = 1;
    tick(); start = 0;
    repeat (3) tick();
    tick(); vsync = 0;
    repeat (3) tick();
    tick(); vsync = 1;
    repeat (5) tick();
    for (int y = 0; y < H && !stop; y++) begin
      for (int x = 0; x < W && !stop; x++) begin
        if (short_after > 0 && cnt == short_after) begin
          tick(); video_on = 0; vsync = 0;
          repeat (3) tick();
          tick(); vsync = 1;
          stop = 1;
        end else if (reset_at > 0 && cnt == reset_at) begin
          @(posedge clk);
          #3 rst_n = 0;
          #1 check_reset_outputs();
          video_on = 0;
          repeat (3) tick();
          @(negedge clk);
          #2 rst_n = 1;
          return;
        end else begin
          if (stall_at > 0 && cnt == stall_at) stall_left = 200;
          tick(); video_on = 1; pixel = gen(kind, y, x);
          cnt++;
        end
      end
      if (!stop) repeat (12) begin tick(); video_on = 0; pixel = PB'($urandom); end
    end
    video_on = 0;
    budget = 0;
    while (done_count == done_base && budget < 4000) begin tick(); budget++; end
    check("frame_done_seen", 32'(done_count > done_base), 1);
    repeat (4) tick();
  endtask

  function automatic int seq_errors(input bit zero_data);
    int bad;
    bad = 0;
    for (int k = 0; k < flen(); k++) begin
      if (fl(k)[31:16] != 16'(k)) bad++;
      if (zero_data && fl(k)[15:0] != 16'h0000) bad++;
    end
    return bad;
  endfunction

  initial begin
    #1 rst_n = 0;
    #2 check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1;

    rmode = 0;
    run_frame(0, 0, 0, 0);
    check("A_writes", 32'(flen()), WORDS);
    check("A_seq_zero", 32'(seq_errors(1)), 0);
    check("A_done_once", 32'(done_count - done_base), 1);
    check("A_overflow", 32'(ovf), 0);
    check("A_short", 32'(shrt), 0);
    check("A_model_words", 32'(pushed.size()), WORDS);

    run_frame(1, 0, 0, 0);
    check("B_writes", 32'(flen()), WORDS);
    check("B_word0", 32'(fl(0)[15:0]), 32'h0000FFFF);
    check("B_word1", 32'(fl(1)[15:0]), 0);

    run_frame(2, 0, 0, 0);
    check("C_word0", 32'(fl(0)[15:0]), 32'h0001);

    run_frame(3, 0, 0, 100);
    check("D_overflow", 32'(ovf), 1);
    check("D_dropped", 32'(flen() < WORDS), 1);
    check("D_last_addr", 32'(fl(flen() - 1)[31:16]), WORDS - 1);
    check("D_done_once", 32'(done_count - done_base), 1);

    rmode = 1;
    run_frame(3, 0, 0, 0);
    check("E_writes", 32'(flen()), WORDS);
    check("E_seq", 32'(seq_errors(0)), 0);
    check("E_overflow", 32'(ovf), 0);

    rmode = 0;
    run_frame(3, 1000, 0, 0);
    check("F_writes", 32'(flen()), 62);
    check("F_short", 32'(shrt), 1);
    check("F_done_once", 32'(done_count - done_base), 1);
    check("F_model_words", 32'(pushed.size()), 62);

    rmode = 2;
    run_frame(3, 0, 500, 0);
    run_frame(3, 0, 0, 0);
    check("G_first_addr", 32'(fl(0)[31:16]), 0);
    check("G_writes", 32'(flen()), WORDS);

    run_frame(3, 0, 0, 0);
    check("H_writes", 32'(flen()), WORDS);
    check("H_seq", 32'(seq_errors(0)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Synthesizable receiving end of the VGA pixel stream.
- Runs on the pixel clock beside vga_sync and samples pixel_in while video is on.
- Thresholds each pixel to 1 bit and packs 16 pixels per word.
- Pushes words through a small FIFO to a memory write port with a valid/ready handshake, so a full frame can be read back and checked in hardware.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- PIXEL_BITS, 12, width of pixel_in.
- WORD_WIDTH, 16, pixels packed per write word; WIDTH must be a multiple of it.
- ADDRESS_WIDTH, 16, width of write_address_out.
- FIFO_DEPTH, 4, word FIFO entries; power of two, at least 2.

Ports:
- clock_in  input  1  pixel clock; all logic on its rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  one-cycle pulse that arms capture of the next frame.
- video_on_in  input  1  active-area qualifier from vga_sync.
- v_sync_in  input  1  vertical sync, active low.
- pixel_in  input  PIXEL_BITS  pixel value.
- write_ready_in  input  1  memory accepts a word this cycle.
- write_valid_out  output  1  FIFO head is valid.
- write_address_out  output  ADDRESS_WIDTH  word index of the FIFO head.
- write_data_out  output  WORD_WIDTH  packed pixels of the FIFO head.
- busy_out  output  1  high in every state except IDLE.
- frame_done_out  output  1  one-cycle completion pulse.
- overflow_out  output  1  sticky; a word was dropped because the FIFO was full.
- short_frame_out  output  1  sticky; v_sync arrived before all WIDTH*HEIGHT pixels.
- crc_out  output  16  frame CRC (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
- Pixel bit: 1 when pixel_in is nonzero (reduction OR).
- Packing order: first pixel goes to bit WORD_WIDTH-1 (MSB first).
- Word address: starts at 0 and increments per completed word, row-major. Final address is WIDTH*HEIGHT/WORD_WIDTH-1 (19199 at defaults).
- State machine:
  - IDLE: on start_in, clear overflow_out, short_frame_out and crc, then go to ARM. start_in is ignored in every other state.
  - ARM: wait for v_sync_in low, then go to SYNC.
  - SYNC: wait for v_sync_in high, then go to CAPTURE.
  - CAPTURE: every cycle with video_on_in=1 shifts in one pixel bit and increments pixel_count.
    - When a word completes it is pushed to the FIFO on the following edge (push latency 1 cycle).
    - After pixel WIDTH*HEIGHT is pushed, go to DRAIN.
    - If v_sync_in goes low before that: discard the partial word, set short_frame_out, go to DRAIN.
  - DRAIN: when the FIFO is empty, go to DONE.
  - DONE: frame_done_out=1 for one cycle, then go to IDLE.
- FIFO:
  - Handshake: a word transfers on a cycle with write_valid_out & write_ready_in. Outputs hold stable while valid is high and ready is low.
  - Push and pop in the same cycle are allowed, including when the FIFO is full. The pop frees the entry, so there is no overflow in that case.
  - Push while full with no pop: the word is dropped, overflow_out is set, and the address still advances.
- Address counter wraps modulo 2^ADDRESS_WIDTH. Wrap never occurs at defaults.
- Reset asserted mid-frame: immediate return to the reset state; the FIFO contents are lost.

Optional Feature:
- Macro: FRAME_CRC_EN.
- Defined:
  - crc_out is a CRC-16-CCITT (poly 0x1021, init 0xFFFF), updated over each pushed word's 16 bits, MSB first.
  - Dropped words are still included in the CRC.
  - The value is valid from the frame_done_out cycle until the next start_in.
- Not defined: crc_out is constant 0 and no CRC logic is generated.

Test Plan:
- All-zero pixels, write_ready_in=1, one frame: 19200 writes with addresses 0..19199, all data 0x0000, frame_done_out once, both sticky flags 0.
- Line 0 pixels 0..15 = 0xFFF, rest 0, ready=1: word 0 = 0xFFFF, word 1 = 0x0000. With only pixel 15 set, word 0 = 0x0001.
- write_ready_in=0 for 200 cycles mid-line: FIFO fills after 4 words, overflow_out=1, later addresses are not shifted, and frame_done_out still occurs.
- Ready toggling every other cycle: every word delivered, and data/address stay stable while valid & !ready.
- v_sync_in pulled low after 1000 pixels: short_frame_out=1, exactly 62 words written, frame_done_out pulses.
- reset_n_in low during CAPTURE, then start_in again: outputs 0 immediately, and the next frame starts at address 0. With FRAME_CRC_EN, an all-zero frame gives a CRC matching the bench reference model.
